// File: rtl/l1l2_pkg.sv
// Shared L1/L2 definitions: responder FSM states, trace command codes and
// the critical-word-first address wrap used by the L2 model and the L1 benches.
package l1l2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } l2_state_e;

    localparam logic [1:0] CMD_DATA_READ  = 2'd0;
    localparam logic [1:0] CMD_DATA_WRITE = 2'd1;
    localparam logic [1:0] CMD_IFETCH     = 2'd2;

    // Beat k of the line containing addr; burst_len must be a power of 2.
    function automatic logic [63:0] wrap_addr(input logic [63:0] addr,
                                              input int unsigned k,
                                              input int unsigned burst_len = 4);
        logic [63:0] mask;
        mask = 64'(burst_len) - 64'd1;
        return (addr & ~mask) | ((addr + 64'(k)) & mask);
    endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// L1/L2 strobe-protocol bus: request handshake plus per-beat strobe and data.
interface l2_burst_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wdata;
    logic              stb;
    logic              stb_last;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] beat_addr;

    modport master (
        output req_valid, req_we, req_addr, wdata,
        input  req_ready, stb, stb_last, rdata, beat_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, wdata,
        output req_ready, stb, stb_last, rdata, beat_addr
    );
endinterface

// File: rtl/l2_word_store.sv
// DEPTH x DATA_W word array with per-word valid bits; one write port,
// one combinational read port, valid bits cleared by synchronous reset.
module l2_word_store #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Data words are not reset; an interrupted write leaves them stale but invalid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_idx];
    assign rd_valid = valid[rd_idx];
endmodule

// File: rtl/l2_burst_responder.sv
// L2-side responder: accepts one L1 request, waits LATENCY cycles, then moves
// a BURST_LEN-beat line critical word first with wrap, one strobe per beat.
module l2_burst_responder
    import l1l2_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned LATENCY   = 3
) (
    input logic                clk,
    input logic                rst,
    l2_burst_responder_if.slave bus
);
    localparam int unsigned K_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BURST_LEN - 1);

    l2_state_e         state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [K_W-1:0]    k;
    logic [CNT_W-1:0]  cnt;
    logic              stb_q;
    logic              stb_last_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] beat_addr_q;

    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] st_rd_data;
    logic              st_rd_valid;
    logic              ready;

    assign next_addr = ADDR_W'(wrap_addr(64'(addr_q), 32'(k), BURST_LEN));

    // Held low through the final beat so the next accept lands after the last write edge.
    assign ready = (state == IDLE) && !stb_q;

    l2_word_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (stb_q && we_q),
        .wr_idx   (beat_addr_q[IDX_W-1:0]),
        .wr_data  (bus.wdata),
        .rd_idx   (next_addr[IDX_W-1:0]),
        .rd_data  (st_rd_data),
        .rd_valid (st_rd_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            k           <= '0;
            cnt         <= '0;
            stb_q       <= 1'b0;
            stb_last_q  <= 1'b0;
            rdata_q     <= '0;
            beat_addr_q <= '0;
        end else begin
            stb_q      <= 1'b0;
            stb_last_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready) begin
                        we_q   <= bus.req_we;
                        addr_q <= bus.req_addr;
                        k      <= '0;
                        cnt    <= CNT_W'(LATENCY - 1);
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    stb_q       <= 1'b1;
                    stb_last_q  <= (k == K_LAST);
                    beat_addr_q <= next_addr;
                    if (we_q) begin
                        rdata_q <= '0;
                    end else if (st_rd_valid) begin
                        rdata_q <= st_rd_data;
                    end else begin
                        rdata_q <= DATA_W'(next_addr);
                    end
                    k <= k + K_W'(1);
                    if (k == K_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.stb       = stb_q;
    assign bus.stb_last  = stb_last_q;
    assign bus.rdata     = rdata_q;
    assign bus.beat_addr = beat_addr_q;
endmodule
